// File: rtl/doce_mac_table_cfg_master_if.sv
// Request/status and AXI-Lite bundle between the MAC-table config master and its peers.
interface doce_mac_table_cfg_master_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Management-side request and status
    logic              cfg_valid;
    logic              cfg_ready;
    logic [3:0]        cfg_node_id;
    logic [47:0]       cfg_mac_addr;
    logic              cfg_verify;
    logic              cfg_done;
    logic              cfg_error;
    logic [1:0]        cfg_err_code;

    // AXI-Lite towards the MAC ID table
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [DATA_W-1:0] m_axi_wdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    modport master (
        input  cfg_valid, cfg_node_id, cfg_mac_addr, cfg_verify,
        output cfg_ready, cfg_done, cfg_error, cfg_err_code,
        output m_axi_awaddr, m_axi_awvalid, input m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, input m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid, output m_axi_bready,
        output m_axi_araddr, m_axi_arvalid, input m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid, output m_axi_rready
    );

    modport slave (
        output cfg_valid, cfg_node_id, cfg_mac_addr, cfg_verify,
        input  cfg_ready, cfg_done, cfg_error, cfg_err_code,
        input  m_axi_awaddr, m_axi_awvalid, output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid, output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid, input m_axi_bready,
        input  m_axi_araddr, m_axi_arvalid, output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid, input m_axi_rready
    );
endinterface

// File: rtl/doce_mac_table_cfg_master.sv
// AXI-Lite master that writes one MAC ID table entry (LO then HI word),
// optionally reads both words back, and reports a status code.
module doce_mac_table_cfg_master #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned ENTRY_STRIDE   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              aresetn,
    doce_mac_table_cfg_master_if.master       bus
);
    localparam int unsigned CNT_W         = 16;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] CODE_OK        = 2'd0;
    localparam logic [1:0] CODE_RESP      = 2'd1;
    localparam logic [1:0] CODE_MISMATCH  = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT   = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_LO, S_WB_LO, S_WR_HI, S_WB_HI,
        S_RD_LO, S_RR_LO, S_RD_HI, S_RR_HI, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        entry_q, entry_d;
    logic [47:0]        mac_q, mac_d;
    logic               verify_q, verify_d;
    logic [31:0]        awaddr_q, awaddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        araddr_q, araddr_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               arvalid_q, arvalid_d;
    logic               bready_q, bready_d;
    logic               rready_q, rready_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               cfg_done_q, cfg_done_d;
    logic               cfg_error_q, cfg_error_d;
    logic [1:0]         code_q, code_d;

    logic               aw_pend, w_pend, tmo;
    logic [31:0]        new_entry, lo_word, hi_word;

    assign new_entry = BASE_ADDR + 32'(bus.cfg_node_id) * 32'(ENTRY_STRIDE);
    assign lo_word   = mac_q[31:0];
    assign hi_word   = {16'h0000, mac_q[47:32]};

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        entry_d   = entry_q;
        mac_d     = mac_q;
        verify_d  = verify_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        araddr_d  = araddr_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        code_d    = code_q;
        tmo       = (cnt_q == TMO_LAST);
        aw_pend   = awvalid_q & ~bus.m_axi_awready;
        w_pend    = wvalid_q & ~bus.m_axi_wready;

        case (state_q)
            S_IDLE: begin
                if (bus.cfg_valid && cfg_ready_q) begin
                    entry_d   = new_entry;
                    mac_d     = bus.cfg_mac_addr;
                    verify_d  = bus.cfg_verify;
                    awaddr_d  = new_entry;
                    wdata_d   = bus.cfg_mac_addr[31:0];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    code_d    = CODE_OK;
                    state_d   = S_WR_LO;
                end
            end
            S_WR_LO, S_WR_HI: begin
                awvalid_d = aw_pend;
                wvalid_d  = w_pend;
                if (!aw_pend && !w_pend) begin
                    state_d = (state_q == S_WR_LO) ? S_WB_LO : S_WB_HI;
                end else if (tmo) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    code_d    = CODE_TIMEOUT;
                    state_d   = S_DONE;
                end
            end
            S_WB_LO, S_WB_HI: begin
                if (bus.m_axi_bvalid) begin
                    if (bus.m_axi_bresp != 2'b00) begin
                        code_d  = CODE_RESP;
                        state_d = S_DONE;
                    end else if (state_q == S_WB_LO) begin
                        awaddr_d  = entry_q + 32'd4;
                        wdata_d   = hi_word;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_HI;
                    end else if (verify_q) begin
                        araddr_d  = entry_q;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_LO;
                    end else begin
                        code_d  = CODE_OK;
                        state_d = S_DONE;
                    end
                end else if (tmo) begin
                    code_d  = CODE_TIMEOUT;
                    state_d = S_DONE;
                end
            end
            S_RD_LO, S_RD_HI: begin
                if (bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = (state_q == S_RD_LO) ? S_RR_LO : S_RR_HI;
                end else if (tmo) begin
                    arvalid_d = 1'b0;
                    code_d    = CODE_TIMEOUT;
                    state_d   = S_DONE;
                end
            end
            S_RR_LO, S_RR_HI: begin
                if (bus.m_axi_rvalid) begin
                    if (bus.m_axi_rresp != 2'b00) begin
                        code_d  = CODE_RESP;
                        state_d = S_DONE;
                    end else if (bus.m_axi_rdata != ((state_q == S_RR_LO) ? lo_word : hi_word)) begin
                        code_d  = CODE_MISMATCH;
                        state_d = S_DONE;
                    end else if (state_q == S_RR_LO) begin
                        araddr_d  = entry_q + 32'd4;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_HI;
                    end else begin
                        code_d  = CODE_OK;
                        state_d = S_DONE;
                    end
                end else if (tmo) begin
                    code_d  = CODE_TIMEOUT;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Wait counter restarts on every state change, idles in IDLE/DONE
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != S_IDLE && state_q != S_DONE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        cfg_ready_d = (state_d == S_IDLE);
        cfg_done_d  = (state_d == S_DONE);
        bready_d    = (state_d == S_WB_LO) || (state_d == S_WB_HI);
        rready_d    = (state_d == S_RR_LO) || (state_d == S_RR_HI);
        cfg_error_d = (code_d != CODE_OK);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            entry_q     <= '0;
            mac_q       <= '0;
            verify_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            araddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_error_q <= 1'b0;
            code_q      <= CODE_OK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            entry_q     <= entry_d;
            mac_q       <= mac_d;
            verify_q    <= verify_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            araddr_q    <= araddr_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_done_q  <= cfg_done_d;
            cfg_error_q <= cfg_error_d;
            code_q      <= code_d;
        end
    end

    assign bus.cfg_ready     = cfg_ready_q;
    assign bus.cfg_done      = cfg_done_q;
    assign bus.cfg_error     = cfg_error_q;
    assign bus.cfg_err_code  = code_q;
    assign bus.m_axi_awaddr  = awaddr_q;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = 4'hF;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;
endmodule

// File: tb/tb_doce_mac_table_cfg_master.sv
// Bench for the MAC-table config master: AXI-Lite slave with tunable delays
// and fault injection, plus a transaction-level reference model.
module tb_doce_mac_table_cfg_master;
    localparam int unsigned T      = 16;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int unsigned STRIDE = 8;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    doce_mac_table_cfg_master_if bus();

    doce_mac_table_cfg_master #(
        .BASE_ADDR(BASE), .ENTRY_STRIDE(STRIDE), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .aresetn(aresetn), .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave knobs (delays in cycles; idx = which word of the transaction misbehaves, -1 none)
    int aw_d, w_d, b_d, ar_d, r_d, b_err_idx, r_err_idx, bad_idx;

    task automatic knobs(input int aw, input int w, input int b, input int ar, input int r,
                         input int be, input int re, input int bd);
        aw_d = aw; w_d = w; b_d = b; ar_d = ar; r_d = r;
        b_err_idx = be; r_err_idx = re; bad_idx = bd;
    endtask

    // Slave state and logs
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
    bit          aw_tk, w_tk, b_pend, r_pend;
    int          aw_c, w_c, b_c, ar_c, r_c, wr_idx, rd_idx;
    logic [31:0] aw_a, w_dat, r_word;
    logic [1:0]  b_resp_v, r_resp_v;
    int          hs_count = 0, strobe_bad = 0, unstable = 0;
    bit          aw_hold, w_hold, ar_hold;
    logic [31:0] aw_hold_v, w_hold_v, ar_hold_v;

    // AXI-Lite slave: handshakes sampled on posedge, responses driven on negedge
    initial begin
        bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_bvalid = 1'b0;
        bus.m_axi_bresp = 2'b00; bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata = '0; bus.m_axi_rresp = 2'b00;
        aw_tk = 0; w_tk = 0; b_pend = 0; r_pend = 0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; wr_idx = 0; rd_idx = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0;
        forever begin
            @(posedge clk);
            if (aresetn) begin
                if (aw_hold && bus.m_axi_awvalid && bus.m_axi_awaddr !== aw_hold_v) unstable++;
                if (w_hold && bus.m_axi_wvalid && bus.m_axi_wdata !== w_hold_v) unstable++;
                if (ar_hold && bus.m_axi_arvalid && bus.m_axi_araddr !== ar_hold_v) unstable++;
                aw_hold = bus.m_axi_awvalid && !bus.m_axi_awready; aw_hold_v = bus.m_axi_awaddr;
                w_hold  = bus.m_axi_wvalid && !bus.m_axi_wready;   w_hold_v  = bus.m_axi_wdata;
                ar_hold = bus.m_axi_arvalid && !bus.m_axi_arready; ar_hold_v = bus.m_axi_araddr;
                if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                    aw_tk = 1; aw_a = bus.m_axi_awaddr; hs_count++;
                end
                if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                    w_tk = 1; w_dat = bus.m_axi_wdata; hs_count++;
                    if (bus.m_axi_wstrb !== 4'hF) strobe_bad++;
                end
                if (aw_tk && w_tk) begin
                    wr_addr_q.push_back(aw_a); wr_data_q.push_back(w_dat);
                    mem[aw_a] = w_dat;
                    b_pend = 1; b_c = 0;
                    b_resp_v = (wr_idx == b_err_idx) ? 2'b10 : 2'b00;
                    wr_idx++; aw_tk = 0; w_tk = 0;
                end
                if (bus.m_axi_bvalid && bus.m_axi_bready) b_pend = 0;
                if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                    hs_count++;
                    rd_addr_q.push_back(bus.m_axi_araddr);
                    r_word = mem.exists(bus.m_axi_araddr) ? mem[bus.m_axi_araddr] : 32'h0;
                    if (rd_idx == bad_idx) r_word = r_word ^ 32'h1;
                    r_resp_v = (rd_idx == r_err_idx) ? 2'b10 : 2'b00;
                    r_pend = 1; r_c = 0; rd_idx++;
                end
                if (bus.m_axi_rvalid && bus.m_axi_rready) r_pend = 0;
            end
            @(negedge clk);
            if (!aresetn || bus.cfg_ready) begin
                aw_tk = 0; w_tk = 0; b_pend = 0; r_pend = 0;
                aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; wr_idx = 0; rd_idx = 0;
                bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bvalid = 0;
                bus.m_axi_arready = 0; bus.m_axi_rvalid = 0;
            end else begin
                if (bus.m_axi_awvalid && !aw_tk) begin
                    if (aw_c >= aw_d) bus.m_axi_awready = 1;
                    else begin bus.m_axi_awready = 0; aw_c++; end
                end else begin bus.m_axi_awready = 0; aw_c = 0; end
                if (bus.m_axi_wvalid && !w_tk) begin
                    if (w_c >= w_d) bus.m_axi_wready = 1;
                    else begin bus.m_axi_wready = 0; w_c++; end
                end else begin bus.m_axi_wready = 0; w_c = 0; end
                if (b_pend) begin
                    if (b_c >= b_d) begin bus.m_axi_bvalid = 1; bus.m_axi_bresp = b_resp_v; end
                    else begin bus.m_axi_bvalid = 0; b_c++; end
                end else bus.m_axi_bvalid = 0;
                if (bus.m_axi_arvalid && !r_pend) begin
                    if (ar_c >= ar_d) bus.m_axi_arready = 1;
                    else begin bus.m_axi_arready = 0; ar_c++; end
                end else begin bus.m_axi_arready = 0; ar_c = 0; end
                if (r_pend) begin
                    if (r_c >= r_d) begin
                        bus.m_axi_rvalid = 1; bus.m_axi_rdata = r_word; bus.m_axi_rresp = r_resp_v;
                    end else begin bus.m_axi_rvalid = 0; r_c++; end
                end else bus.m_axi_rvalid = 0;
            end
        end
    end

    // One request end to end: model expectation, drive, observe, compare
    task automatic run_txn(input logic [3:0] node, input logic [47:0] mac, input bit ver,
                           output int done_cyc, output int wb_cyc);
        logic [31:0] a, lo, hi;
        logic [31:0] ewa[$], ewd[$], era[$];
        int exp_code, exp_cyc, wr0, rd0, cyc, wd;
        a  = BASE + 32'(node) * 32'(STRIDE);
        lo = mac[31:0];
        hi = {16'h0, mac[47:32]};
        exp_code = -1;
        exp_cyc  = 2;
        for (int i = 0; i < 2 && exp_code < 0; i++) begin
            wd = (aw_d > w_d) ? aw_d : w_d;
            if (wd >= int'(T)) begin exp_cyc += T; exp_code = 3; end
            else begin
                exp_cyc += wd + 1;
                ewa.push_back(i == 0 ? a : a + 32'd4);
                ewd.push_back(i == 0 ? lo : hi);
                if (b_d >= int'(T)) begin exp_cyc += T; exp_code = 3; end
                else begin
                    exp_cyc += b_d + 1;
                    if (b_err_idx == i) exp_code = 1;
                end
            end
        end
        if (exp_code < 0 && !ver) exp_code = 0;
        for (int i = 0; i < 2 && exp_code < 0; i++) begin
            if (ar_d >= int'(T)) begin exp_cyc += T; exp_code = 3; end
            else begin
                exp_cyc += ar_d + 1;
                era.push_back(i == 0 ? a : a + 32'd4);
                if (r_d >= int'(T)) begin exp_cyc += T; exp_code = 3; end
                else begin
                    exp_cyc += r_d + 1;
                    if (r_err_idx == i) exp_code = 1;
                    else if (bad_idx == i) exp_code = 2;
                end
            end
        end
        if (exp_code < 0) exp_code = 0;

        @(negedge clk);
        wr0 = wr_addr_q.size();
        rd0 = rd_addr_q.size();
        bus.cfg_valid = 1'b1; bus.cfg_node_id = node; bus.cfg_mac_addr = mac; bus.cfg_verify = ver;
        cyc = 0;
        while (!bus.cfg_ready && cyc < 50) begin @(negedge clk); cyc++; end
        chk("accept_ready", bus.cfg_ready, 1);
        cyc = 1;
        wb_cyc = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                bus.cfg_valid    = 1'b0;
                bus.cfg_node_id  = 4'($urandom);
                bus.cfg_mac_addr = {16'($urandom), 32'($urandom)};
                bus.cfg_verify   = 1'($urandom);
            end
            if (bus.m_axi_bready && wb_cyc < 0) wb_cyc = cyc;
            if (bus.cfg_done || cyc > 300) break;
        end
        done_cyc = cyc;
        chk("done_seen", bus.cfg_done, 1);
        chk("latency", cyc, exp_cyc);
        chk("err_code", bus.cfg_err_code, exp_code);
        chk("error_flag", bus.cfg_error, (exp_code != 0));
        chk("wr_count", wr_addr_q.size() - wr0, ewa.size());
        for (int i = 0; i < ewa.size(); i++) begin
            if (wr0 + i < wr_addr_q.size()) begin
                chk("wr_addr", wr_addr_q[wr0 + i], ewa[i]);
                chk("wr_data", wr_data_q[wr0 + i], ewd[i]);
            end
        end
        chk("rd_count", rd_addr_q.size() - rd0, era.size());
        for (int i = 0; i < era.size(); i++) begin
            if (rd0 + i < rd_addr_q.size()) chk("rd_addr", rd_addr_q[rd0 + i], era[i]);
        end
        @(negedge clk);
        chk("done_pulse", bus.cfg_done, 0);
        chk("back_idle", bus.cfg_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, wc, hs0, wr0;
        bus.cfg_valid = 1'b0; bus.cfg_node_id = '0; bus.cfg_mac_addr = '0; bus.cfg_verify = 1'b0;
        knobs(0, 0, 0, 0, 0, -1, -1, -1);
        repeat (3) @(negedge clk);
        chk("rst_outputs", {bus.cfg_ready, bus.cfg_done, bus.cfg_error, bus.cfg_err_code,
                            bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                            bus.m_axi_arvalid, bus.m_axi_rready}, 0);
        chk("rst_addr", {bus.m_axi_awaddr, bus.m_axi_araddr}, 0);
        aresetn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.cfg_ready, 1);

        // Directed scenarios
        knobs(0, 0, 0, 0, 0, -1, -1, -1);
        run_txn(4'd3, 48'hA1B2_C3D4_E5F6, 1'b0, dc, wc);
        chk("t1_cycle", dc, 6);
        chk("t1_lo", {wr_addr_q[0], wr_data_q[0]}, {32'h18, 32'hC3D4_E5F6});
        chk("t1_hi", {wr_addr_q[1], wr_data_q[1]}, {32'h1C, 32'h0000_A1B2});
        run_txn(4'd3, 48'hA1B2_C3D4_E5F6, 1'b1, dc, wc);
        chk("t2_cycle", dc, 10);
        knobs(3, 0, 0, 0, 0, 0, -1, -1);
        run_txn(4'd5, 48'h0102_0304_0506, 1'b1, dc, wc);
        knobs(0, 0, 0, 0, 0, -1, -1, 1);
        run_txn(4'd3, 48'hA1B2_C3D4_E5F6, 1'b1, dc, wc);
        knobs(0, 0, 1000, 0, 0, -1, -1, -1);
        run_txn(4'd7, 48'hDEAD_BEEF_0001, 1'b0, dc, wc);
        chk("t5_tmo_span", dc - wc, T);
        chk("t5_bready_low", bus.m_axi_bready, 0);
        // Timeout boundary: wait of T-1 completes, T aborts
        knobs(T - 1, 0, 0, 0, 0, -1, -1, -1);
        run_txn(4'd1, 48'h1111_2222_3333, 1'b0, dc, wc);
        knobs(T, 0, 0, 0, 0, -1, -1, -1);
        run_txn(4'd2, 48'h4444_5555_6666, 1'b0, dc, wc);
        knobs(0, 0, 0, 0, T - 1, -1, -1, -1);
        run_txn(4'd15, 48'h7777_8888_9999, 1'b1, dc, wc);
        knobs(0, 0, 0, T, 0, -1, -1, -1);
        run_txn(4'd0, 48'hAAAA_BBBB_CCCC, 1'b1, dc, wc);
        knobs(0, 0, 0, 0, 0, -1, 0, -1);
        run_txn(4'd9, 48'h0000_0000_0001, 1'b1, dc, wc);

        // Randomized requests and slave behaviour
        for (int n = 0; n < 40; n++) begin
            int r1, r2, r3;
            r1 = int'($urandom_range(0, 9));
            r2 = int'($urandom_range(0, 9));
            r3 = int'($urandom_range(0, 9));
            knobs(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  (r1 < 2) ? r1 : -1, (r2 < 2) ? r2 : -1, (r3 < 2) ? r3 : -1);
            run_txn(4'($urandom), {16'($urandom), 32'($urandom)}, 1'($urandom), dc, wc);
        end

        // Asynchronous reset while a write address is being offered
        knobs(1000, 1000, 0, 0, 0, -1, -1, -1);
        @(negedge clk);
        bus.cfg_valid = 1'b1; bus.cfg_node_id = 4'd6; bus.cfg_mac_addr = 48'h1234_5678_9ABC;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.m_axi_awvalid; i++) @(negedge clk);
        chk("rst_pre_awvalid", bus.m_axi_awvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("async_rst_ctl", {bus.cfg_ready, bus.cfg_done, bus.cfg_error, bus.cfg_err_code,
                              bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                              bus.m_axi_arvalid, bus.m_axi_rready}, 0);
        chk("async_rst_data", {bus.m_axi_awaddr, bus.m_axi_wdata}, 0);
        hs0 = hs_count;
        wr0 = wr_addr_q.size();
        @(negedge clk);
        aresetn = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_rel_ready", bus.cfg_ready, 1);
        chk("rst_no_beats", hs_count - hs0, 0);
        chk("rst_no_writes", wr_addr_q.size() - wr0, 0);
        chk("rst_awvalid_low", bus.m_axi_awvalid, 0);
        knobs(0, 0, 0, 0, 0, -1, -1, -1);
        run_txn(4'd6, 48'h1234_5678_9ABC, 1'b1, dc, wc);

        chk("wstrb_full", strobe_bad, 0);
        chk("stable_payload", unstable, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/doce_mac_table_cfg_master.md
Name: doce_mac_table_cfg_master

Overview:
- AXI-Lite master that programs the DoCE transport-layer MAC ID table, i.e. the initiator driving the table's AXI-Lite slave port.
- Accepts one configuration request at a time: node ID plus 48-bit MAC.
- Issues the two 32-bit register writes for that entry, then optionally reads both words back and compares them.
- Reports completion and error status to the management/boot logic.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of table entry 0.
- ENTRY_STRIDE, 8, byte stride between entries. Must be a power of two and ≥ 8.
- TIMEOUT_CYCLES, 1024, maximum wait in any response/ready state before aborting. Range 2..65535.

Ports:
- clk  in  1  single clock domain.
- aresetn  in  1  asynchronous active-low reset.
- cfg_valid  in  1  request valid.
- cfg_ready  out  1  request accepted when cfg_valid & cfg_ready.
- cfg_node_id  in  4  table index (same encoding as transaction-layer tuser).
- cfg_mac_addr  in  48  MAC to store.
- cfg_verify  in  1  perform readback compare after writing.
- cfg_done  out  1  one-cycle pulse at end of every accepted request.
- cfg_error  out  1  valid with cfg_done: 1 = failure.
- cfg_err_code  out  2  valid with cfg_done: 0 OK, 1 bad resp, 2 mismatch, 3 timeout.
- m_axi_awaddr  out  32  write address.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata  out  32  write data.
- m_axi_wstrb  out  4  write strobes, always 4'hF.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_araddr  out  32  read address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.

Behaviour:

Reset:
- On aresetn low, immediately and asynchronously: all valid/ready/done/error outputs = 0, cfg_err_code = 0, addresses/data = 0, FSM = IDLE.
- Reset mid-transaction abandons the transfer; no further beats are issued.

Address and data:
- Entry address A = BASE_ADDR + cfg_node_id*ENTRY_STRIDE, 32-bit wrap.
- LO word at A holds mac[31:0].
- HI word at A+4 holds {16'h0, mac[47:32]}.
- Request fields are registered at acceptance; later input changes are ignored.

Request handshake:
- cfg_ready = 1 only in IDLE.
- Acceptance moves IDLE → WR_LO on the next edge.

FSM states: IDLE, WR_LO, WB_LO, WR_HI, WB_HI, RD_LO, RR_LO, RD_HI, RR_HI, DONE.
- WR_x:
  - awvalid and wvalid assert together in the state's first cycle.
  - Each drops independently on its own handshake (AW and W may complete in any order or the same cycle).
  - Exit to WB_x once both are done.
  - Address/data must stay stable while valid is high.
- WB_x:
  - bready = 1; exit on bvalid.
  - bresp ≠ 2'b00 → DONE with code 1; the HI write is not issued after a failed LO.
  - WB_LO → WR_HI.
  - WB_HI → RD_LO if verify, else DONE with code 0.
- RD_x:
  - arvalid held until arready, then → RR_x.
- RR_x:
  - rready = 1; on rvalid, capture the word.
  - rresp ≠ OKAY → code 1.
  - rdata ≠ expected word → code 2.
  - The first failure terminates to DONE; RR_LO success → RD_HI; RR_HI success → DONE with code 0.
- DONE: cfg_done = 1 for exactly one cycle, with cfg_error/cfg_err_code; then → IDLE. cfg_error = (code ≠ 0).

Timeout:
- A 16-bit counter clears on each state entry and increments in every non-IDLE/DONE state.
- Reaching TIMEOUT_CYCLES → DONE with code 3, deasserting all valids, even mid-handshake.
- A handshake that lands in the same cycle as the timeout takes priority: the transfer completes and no timeout is reported.

Latency:
- Zero-wait slave, no verify: acceptance to cfg_done = 6 cycles.
- With verify: 10 cycles.

Outstanding transactions:
- At most one AXI transaction is outstanding. Reads and writes are never concurrent.

Test Plan:
1. Node 3, MAC 48'hA1B2_C3D4_E5F6, verify=0, zero-wait slave → writes 0x18=32'hC3D4_E5F6 then 0x1C=32'h0000_A1B2; cfg_done at cycle 6 with error 0.
2. Same request, verify=1, slave model returning written data → AR to 0x18 then 0x1C; cfg_done at cycle 10, code 0.
3. Slave accepts W 3 cycles before AW, LO-word bresp=SLVERR → single LO write only, no HI write; done with code 1.
4. Verify=1, slave returns HI word 32'h0000_A1B3 → done with code 2, error=1.
5. Slave never asserts bvalid, TIMEOUT_CYCLES=16 → done with code 3 exactly 16 cycles after WB_LO entry; bready drops.
6. aresetn pulsed low while awvalid is high → all outputs 0 asynchronously; after release cfg_ready=1 and no stray AXI beats.
